circuit5_delay_pipe: RTL and testbench
======================================

CIRCUIT5_DELAY_PIPE -- requirements
Module: circuit5_delay_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit-width of every data vector; each bit is an independent lane.
REQ-002 SHALL have parameters D_OR, D_NAND, D_XOR, D_AND and D_NOR, defaults 6, 3, 5, 4 and 7: per-gate delay in clock cycles, each >=1.
REQ-003 SHALL have parameter CNT_W, default 16: toggle-counter width.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have ports a, b and c, input, WIDTH bits each: circuit inputs, sampled every rising edge.
REQ-007 SHALL have port clr_cnt, input, 1 bit: synchronous clear of toggle_cnt.
REQ-008 SHALL have port o, output, WIDTH bits: circuit output.
REQ-009 SHALL have port settled, output, 1 bit: high once the inputs have been stable for LAT cycles.
REQ-010 SHALL have port toggle_cnt, output, CNT_W bits: saturating count of cycles in which o changed.

Function
REQ-011 SHALL model five gates per lane, each as a transport delay line of its D_x cycles:
- w = OR(a, b)
- y = NAND(w, c)
- n = XOR(a, y)
- z = AND(b, n)
- o = NOR(z, c)
REQ-012 Timing rule: a gate output after edge t SHALL equal its function of the gate inputs as held after edge t-D_x.
- Primary inputs count as held after the edge that samples them.
REQ-013 Delay lines SHALL be pure transport: no inertial filtering, so pulses of 1 cycle propagate unchanged.
REQ-014 Hazards produced by unequal path delays SHALL appear on o exactly as the timing rule dictates.
REQ-015 LAT SHALL equal D_OR+D_NAND+D_XOR+D_AND+D_NOR (25 at defaults), the longest input-to-o path.
REQ-016 The block SHALL hold a registered copy of a, b and c (a_q, b_q, c_q).
- An input change is any edge where {a,b,c} != {a_q,b_q,c_q}.
REQ-017 Settle counter SHALL clear to 0 on an input change, else increment, saturating at LAT.
- settled = (count == LAT).
REQ-018 toggle_cnt SHALL increment by 1 on every edge where the next o differs from the current o in any bit.
- Saturates at 2^CNT_W-1.
REQ-019 When clr_cnt and a toggle coincide, clr_cnt SHALL win: toggle_cnt becomes 0.
REQ-020 Lanes SHALL be independent: a change in lane i SHALL NOT affect o in lane j != i.
REQ-021 Parameter values below 1 SHALL be rejected at elaboration.

Reset
REQ-022 rst_n low SHALL immediately and asynchronously load every delay-line stage with the all-zero-input steady state, per bit:
- w=0, y=1, n=1, z=0, o=1
REQ-023 During reset:
- o = all ones
- a_q, b_q, c_q = 0
- settle count = 0 and settled = 0
- toggle_cnt = 0
REQ-024 Reset asserted mid-propagation SHALL discard all in-flight values with no residual pulse on o after release.
REQ-025 Reset release SHALL be synchronised externally; first state update on the first rising edge with rst_n high.

Structure
REQ-026 Shared package circuit_delay_pkg SHALL hold:
- default delay constants
- the LAT computation function
- gate reset-value constants
REQ-027 SHALL use one sub-module, delay_line, with parameters WIDTH, DEPTH and RESET_VAL; it is instantiated once per gate.
REQ-028 Implementation SHALL be synchronous registers only; no # delays in RTL.

Verification (WIDTH=8, default delays, inputs applied at edge 0 after reset)
REQ-029 Reset steady state: a=b=c=0 held -> o=0xFF throughout, settled=1 from edge 25, toggle_cnt=0.
REQ-030 Short path: b=0xFF, a=c=0 -> o=0xFF through edge 10, o=0x00 from edge 11, toggle_cnt=1, settled=1 at edge 25.
REQ-031 Direct c path: c=0xFF, a=b=0 -> o=0x00 from edge 7, toggle_cnt=1.
REQ-032 Hazard: a=b=0xFF, c=0 -> o=0x00 for edges 11-15, o=0xFF from edge 16, toggle_cnt=2.
REQ-033 Lane independence plus clear:
- b=0x01 -> only o[0] falls at edge 11.
- clr_cnt pulsed on edge 11 -> toggle_cnt=0 after it.
REQ-034 Reset mid-flight: b=0xFF, then rst_n low at edge 5 and high at edge 8 with inputs returned to 0 -> o=0xFF continuously, toggle_cnt=0.

Source files
------------

// File: rtl/circuit_delay_pkg.sv
// Shared constants for the five-gate delay pipe: default gate delays,
// reset (all-inputs-zero steady state) value of each gate output, and
// the input-to-output latency helper.
package circuit_delay_pkg;

    localparam int D_OR_DEF   = 6;
    localparam int D_NAND_DEF = 3;
    localparam int D_XOR_DEF  = 5;
    localparam int D_AND_DEF  = 4;
    localparam int D_NOR_DEF  = 7;

    // Steady state with a=b=c=0: w=0, y=1, n=1, z=0, o=1.
    localparam logic RST_W = 1'b0;
    localparam logic RST_Y = 1'b1;
    localparam logic RST_N = 1'b1;
    localparam logic RST_Z = 1'b0;
    localparam logic RST_O = 1'b1;

    // Longest input-to-o path runs through every gate once.
    function automatic int calc_lat(input int d_or, input int d_nand,
                                    input int d_xor, input int d_and,
                                    input int d_nor);
        return d_or + d_nand + d_xor + d_and + d_nor;
    endfunction

endpackage

// File: rtl/circuit5_delay_pipe_delay_line.sv
// Transport delay line: DEPTH registers per lane, no filtering, so every
// single-cycle pulse arrives intact DEPTH edges later. dout_next exposes
// the value dout will take on the coming edge.
module delay_line #(
    parameter int   WIDTH     = 8,
    parameter int   DEPTH     = 1,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] dout_next
);

    if (DEPTH < 1 || WIDTH < 1) begin : g_bad_param
        $error("delay_line: DEPTH and WIDTH must be >= 1");
    end

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    // Shift: stage 0 takes the gate function, each later stage its predecessor.
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Stage registers; reset flushes every in-flight value to the steady state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= {(DEPTH*WIDTH){RESET_VAL}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout      = stage_q[DEPTH-1];
    assign dout_next = stage_d[DEPTH-1];

endmodule

// File: rtl/circuit5_delay_pipe.sv
// Five-gate circuit (OR, NAND, XOR, AND, NOR) per lane, each gate a
// transport delay line, plus an input-settle detector and a saturating
// count of cycles in which o changes.
module circuit5_delay_pipe
    import circuit_delay_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int D_OR   = D_OR_DEF,
    parameter int D_NAND = D_NAND_DEF,
    parameter int D_XOR  = D_XOR_DEF,
    parameter int D_AND  = D_AND_DEF,
    parameter int D_NOR  = D_NOR_DEF,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] o,
    output logic             settled,
    output logic [CNT_W-1:0] toggle_cnt
);

    if (WIDTH < 1 || D_OR < 1 || D_NAND < 1 || D_XOR < 1 ||
        D_AND < 1 || D_NOR < 1 || CNT_W < 1) begin : g_bad_param
        $error("circuit5_delay_pipe: all parameters must be >= 1");
    end

    localparam int LAT   = calc_lat(D_OR, D_NAND, D_XOR, D_AND, D_NOR);
    localparam int SET_W = $clog2(LAT + 1);
    localparam logic [SET_W-1:0] LAT_C = SET_W'(LAT);

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [SET_W-1:0] set_cnt_q, set_cnt_d;
    logic [CNT_W-1:0] tog_cnt_q, tog_cnt_d;

    logic [WIDTH-1:0] w, y, n, z, o_cur;
    logic [WIDTH-1:0] w_nxt, y_nxt, n_nxt, z_nxt, o_nxt;
    logic             unused_nxt;

    // Gate chain; each gate sees the held inputs and upstream gate outputs.
    delay_line #(.WIDTH(WIDTH), .DEPTH(D_OR), .RESET_VAL(RST_W)) u_or (
        .clk(clk), .rst_n(rst_n), .din(a_q | b_q),
        .dout(w), .dout_next(w_nxt));

    delay_line #(.WIDTH(WIDTH), .DEPTH(D_NAND), .RESET_VAL(RST_Y)) u_nand (
        .clk(clk), .rst_n(rst_n), .din(~(w & c_q)),
        .dout(y), .dout_next(y_nxt));

    delay_line #(.WIDTH(WIDTH), .DEPTH(D_XOR), .RESET_VAL(RST_N)) u_xor (
        .clk(clk), .rst_n(rst_n), .din(a_q ^ y),
        .dout(n), .dout_next(n_nxt));

    delay_line #(.WIDTH(WIDTH), .DEPTH(D_AND), .RESET_VAL(RST_Z)) u_and (
        .clk(clk), .rst_n(rst_n), .din(b_q & n),
        .dout(z), .dout_next(z_nxt));

    delay_line #(.WIDTH(WIDTH), .DEPTH(D_NOR), .RESET_VAL(RST_O)) u_nor (
        .clk(clk), .rst_n(rst_n), .din(~(z | c_q)),
        .dout(o_cur), .dout_next(o_nxt));

    // Only the output gate's look-ahead feeds the toggle counter.
    assign unused_nxt = ^{w_nxt, y_nxt, n_nxt, z_nxt};

    // Next-state: input capture, settle counter, toggle counter (clear wins).
    always_comb begin
        a_d       = a;
        b_d       = b;
        c_d       = c;
        set_cnt_d = set_cnt_q;
        tog_cnt_d = tog_cnt_q;

        if ({a, b, c} != {a_q, b_q, c_q}) begin
            set_cnt_d = '0;
        end else if (set_cnt_q != LAT_C) begin
            set_cnt_d = set_cnt_q + 1'b1;
        end

        if (clr_cnt) begin
            tog_cnt_d = '0;
        end else if (o_nxt != o_cur && tog_cnt_q != {CNT_W{1'b1}}) begin
            tog_cnt_d = tog_cnt_q + 1'b1;
        end
    end

    // Held inputs and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            set_cnt_q <= '0;
            tog_cnt_q <= '0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            set_cnt_q <= set_cnt_d;
            tog_cnt_q <= tog_cnt_d;
        end
    end

    assign o          = o_cur;
    assign settled    = (set_cnt_q == LAT_C);
    assign toggle_cnt = tog_cnt_q;

endmodule

// File: tb/tb_circuit5_delay_pipe.sv
// Bench for circuit5_delay_pipe: history-based reference (each gate value
// looked up from input history D cycles back), directed literal checks and
// randomized stimulus.
module tb_circuit5_delay_pipe;

    localparam int W = 8;
    localparam int DOR = 6, DNA = 3, DXO = 5, DAN = 4, DNO = 7;
    localparam int LAT = 25;
    localparam int CW = 16;
    localparam int MAXE = 512;
    localparam int HA = 0, HB = 1, HC = 2, HW = 3, HY = 4, HN = 5, HZ = 6, HO = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [W-1:0] a = '0, b = '0, c = '0;
    logic clr_cnt = 1'b0;
    logic [W-1:0] o;
    logic settled;
    logic [CW-1:0] toggle_cnt;

    always #5 clk = ~clk;

    circuit5_delay_pipe #(.WIDTH(W), .D_OR(DOR), .D_NAND(DNA), .D_XOR(DXO),
                          .D_AND(DAN), .D_NOR(DNO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .clr_cnt(clr_cnt),
        .o(o), .settled(settled), .toggle_cnt(toggle_cnt));

    int n_chk = 0;
    int n_fail = 0;

    // Reference history, indexed by edge number since reset release.
    logic [W-1:0] ah[MAXE], bh[MAXE], ch[MAXE];
    logic [W-1:0] wv[MAXE], yv[MAXE], nv[MAXE], zv[MAXE], ov[MAXE];
    logic [W-1:0] dut_o[MAXE];
    logic         dut_set[MAXE];
    logic [CW-1:0] dut_tc[MAXE];
    int e = 0;
    int lc = -1;
    int tc = 0;

    logic [W-1:0]  exp_o = '1;
    logic          exp_set = 1'b0;
    logic [CW-1:0] exp_tc = '0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Value after edge i; before release everything sits at the zero-input steady state.
    function automatic logic [W-1:0] hist(input int sel, input int i);
        if (i < 0) return (sel == HY || sel == HN || sel == HO) ? '1 : '0;
        case (sel)
            HA: return ah[i];
            HB: return bh[i];
            HC: return ch[i];
            HW: return wv[i];
            HY: return yv[i];
            HN: return nv[i];
            HZ: return zv[i];
            default: return ov[i];
        endcase
    endfunction

    task automatic model_update(input logic [W-1:0] ai, bi, ci, input logic clr);
        ah[e] = ai; bh[e] = bi; ch[e] = ci;
        wv[e] = hist(HA, e-DOR) | hist(HB, e-DOR);
        yv[e] = ~(hist(HW, e-DNA) & hist(HC, e-DNA));
        nv[e] = hist(HA, e-DXO) ^ hist(HY, e-DXO);
        zv[e] = hist(HB, e-DAN) & hist(HN, e-DAN);
        ov[e] = ~(hist(HZ, e-DNO) | hist(HC, e-DNO));
        if ({ai, bi, ci} != {hist(HA, e-1), hist(HB, e-1), hist(HC, e-1)}) lc = e;
        if (clr) tc = 0;
        else if (ov[e] != hist(HO, e-1) && tc < 65535) tc++;
        exp_o   = ov[e];
        exp_set = ((e - lc) >= LAT);
        exp_tc  = CW'(tc);
    endtask

    task automatic step(input logic [W-1:0] ai, bi, ci, input logic clr);
        a = ai; b = bi; c = ci; clr_cnt = clr;
        @(posedge clk);
        #1;
        model_update(ai, bi, ci, clr);
        dut_o[e] = o; dut_set[e] = settled; dut_tc[e] = toggle_cnt;
        e++;
    endtask

    task automatic enter_reset();
        rst_n = 1'b0;
        a = '0; b = '0; c = '0; clr_cnt = 1'b0;
        exp_o = '1; exp_set = 1'b0; exp_tc = '0;
        e = 0; lc = -1; tc = 0;
    endtask

    task automatic do_reset();
        enter_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Every cycle: DUT outputs versus the reference.
    always @(negedge clk) begin
        if (chk_en) begin
            check("o", 32'(o), 32'(exp_o));
            check("settled", 32'(settled), 32'(exp_set));
            check("toggle_cnt", 32'(toggle_cnt), 32'(exp_tc));
        end
    end

    initial begin
        bit all_ff;
        logic [W-1:0] ra, rb, rc;
        chk_en = 1'b1;
        do_reset();

        // Reset steady state held.
        for (int i = 0; i < 30; i++) step('0, '0, '0, 1'b0);
        check("r29_o25", 32'(dut_o[25]), 32'hFF);
        check("r29_set25", 32'(dut_set[25]), 32'd1);
        check("r29_tc", 32'(dut_tc[29]), 32'd0);

        // Short path through AND/NOR.
        do_reset();
        for (int i = 0; i < 30; i++) step('0, 8'hFF, '0, 1'b0);
        check("r30_o10", 32'(dut_o[10]), 32'hFF);
        check("r30_o11", 32'(dut_o[11]), 32'h00);
        check("r30_set24", 32'(dut_set[24]), 32'd0);
        check("r30_set25", 32'(dut_set[25]), 32'd1);
        check("r30_tc", 32'(dut_tc[29]), 32'd1);

        // Direct c path.
        do_reset();
        for (int i = 0; i < 20; i++) step('0, '0, 8'hFF, 1'b0);
        check("r31_o6", 32'(dut_o[6]), 32'hFF);
        check("r31_o7", 32'(dut_o[7]), 32'h00);
        check("r31_tc", 32'(dut_tc[19]), 32'd1);

        // Hazard pulse from unequal paths.
        do_reset();
        for (int i = 0; i < 30; i++) step(8'hFF, 8'hFF, '0, 1'b0);
        check("r32_o10", 32'(dut_o[10]), 32'hFF);
        check("r32_o11", 32'(dut_o[11]), 32'h00);
        check("r32_o15", 32'(dut_o[15]), 32'h00);
        check("r32_o16", 32'(dut_o[16]), 32'hFF);
        check("r32_tc", 32'(dut_tc[29]), 32'd2);

        // Single lane plus clear coinciding with the toggle.
        do_reset();
        for (int i = 0; i < 25; i++) step('0, 8'h01, '0, (i == 11));
        check("r33_o10", 32'(dut_o[10]), 32'hFF);
        check("r33_o11", 32'(dut_o[11]), 32'hFE);
        check("r33_o20", 32'(dut_o[20]), 32'hFE);
        check("r33_tc11", 32'(dut_tc[11]), 32'd0);
        check("r33_tc24", 32'(dut_tc[24]), 32'd0);

        // Reset mid-flight: nothing in flight may reach o.
        do_reset();
        for (int i = 0; i < 5; i++) step('0, 8'hFF, '0, 1'b0);
        enter_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        all_ff = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step('0, '0, '0, 1'b0);
            if (o !== 8'hFF) all_ff = 1'b0;
        end
        check("r34_all_ff", 32'(all_ff), 32'd1);
        check("r34_tc", 32'(dut_tc[29]), 32'd0);

        // Randomized: bursts of changes alternating with long holds.
        do_reset();
        ra = '0; rb = '0; rc = '0;
        for (int i = 0; i < 400; i++) begin
            int p;
            p = ((i % 100) < 50) ? 3 : 40;
            if ($urandom_range(p - 1) == 0) begin
                ra = W'($urandom);
                rb = W'($urandom);
                rc = ($urandom_range(2) == 0) ? W'($urandom) : '0;
            end
            step(ra, rb, rc, ($urandom_range(15) == 0));
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
